seg_scan8: RTL and testbench

Time-multiplexed driver for an 8-digit, common-anode seven-segment display. It takes a 32-bit hex value with per-digit enable and decimal-point masks. It scans one digit at a time by decoding a 3-bit digit index into a one-hot active-low anode select, and converts each nibble to active-low segments. It sits between the core's display register writes and the board pins, and is the output-side counterpart of the switch-to-code encoder path. New values are double-buffered and committed only at frame boundaries, so the display never tears.

---
 rtl/seg_scan8.sv | 192 +++++++++++++++++++
 tb/tb_seg_scan8.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan8.sv
// seg_scan8: time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Scans one digit every DIV cycles, decoding a 3-bit index into an active-low anode select
// and each nibble into active-low segments. New values are double-buffered and take effect
// only at frame boundaries, so a frame never mixes old and new digits.
module seg_scan8 #(
    parameter int unsigned DIV = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] value,
    input  logic [7:0]  mask,
    input  logic [7:0]  dp,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [7:0]  an_n,
    output logic [2:0]  digit_idx,
    output logic        frame_done
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    // Blank-display output codes
    localparam logic [6:0] SegBlank = 7'h7F;
    localparam logic [7:0] AnBlank  = 8'hFF;

    // Scan position
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;

    // Pending (staged) display set
    logic            pend_q, pend_d;
    logic [31:0]     pend_value_q, pend_value_d;
    logic [7:0]      pend_mask_q, pend_mask_d;
    logic [7:0]      pend_dp_q, pend_dp_d;

    // Active (displayed) set
    logic [31:0]     act_value_q, act_value_d;
    logic [7:0]      act_mask_q, act_mask_d;
    logic [7:0]      act_dp_q, act_dp_d;

    // Registered pin drivers
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [7:0]      an_q, an_d;
    logic [2:0]      digit_idx_q;
    logic            frame_done_q;

    logic            digit_wrap;
    logic            boundary;
    logic            commit_window;

    // Nibble to active-low segments, bit6=a .. bit0=g
    function automatic logic [6:0] seg_lut(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign digit_wrap    = en && (cnt_q == CntMax);
    assign boundary      = digit_wrap && (idx_q == 3'd7);
    // While disabled there is no frame to tear, so commits happen every cycle
    assign commit_window = !en || boundary;

    // Divider and scan index: held at zero while disabled
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!en) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (digit_wrap) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Double buffer: stage loads, commit at frame boundary (a coincident load bypasses staging)
    always_comb begin
        pend_d       = pend_q;
        pend_value_d = pend_value_q;
        pend_mask_d  = pend_mask_q;
        pend_dp_d    = pend_dp_q;
        act_value_d  = act_value_q;
        act_mask_d   = act_mask_q;
        act_dp_d     = act_dp_q;
        if (commit_window) begin
            if (load) begin
                act_value_d = value;
                act_mask_d  = mask;
                act_dp_d    = dp;
            end else if (pend_q) begin
                act_value_d = pend_value_q;
                act_mask_d  = pend_mask_q;
                act_dp_d    = pend_dp_q;
            end
            pend_d = 1'b0;
        end else if (load) begin
            pend_value_d = value;
            pend_mask_d  = mask;
            pend_dp_d    = dp;
            pend_d       = 1'b1;
        end
    end

    // Output encode from the next-cycle position and active set, so the registered pins line
    // up with digit_idx and with the frame_done pulse that follows a boundary
    always_comb begin
        logic       lit;
        logic [3:0] nib;
        lit  = en && act_mask_d[idx_d];
        nib  = act_value_d[{idx_d, 2'b00} +: 4];
        seg_d = SegBlank;
        dp_d  = 1'b1;
        an_d  = AnBlank;
        if (lit) begin
            seg_d = seg_lut(nib);
            dp_d  = ~act_dp_d[idx_d];
            an_d  = ~(8'h01 << idx_d);
        end
    end

    // Scan and buffer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            pend_value_q <= '0;
            pend_mask_q  <= '0;
            pend_dp_q    <= '0;
            act_value_q  <= '0;
            act_mask_q   <= '0;
            act_dp_q     <= '0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_value_q <= pend_value_d;
            pend_mask_q  <= pend_mask_d;
            pend_dp_q    <= pend_dp_d;
            act_value_q  <= act_value_d;
            act_mask_q   <= act_mask_d;
            act_dp_q     <= act_dp_d;
        end
    end

    // Registered pin drivers; reset leaves the display blank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q        <= SegBlank;
            dp_q         <= 1'b1;
            an_q         <= AnBlank;
            digit_idx_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            digit_idx_q  <= idx_d;
            frame_done_q <= boundary;
        end
    end

    assign seg_n      = seg_q;
    assign dp_n       = dp_q;
    assign an_n       = an_q;
    assign digit_idx  = digit_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan8.sv
// Bench for seg_scan8: directed scenarios plus random traffic, every cycle compared
// against a frame-position model of the display.
module tb_seg_scan8;

    localparam int unsigned DIV   = 4;
    localparam int unsigned FRAME = 8 * DIV;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [31:0] value;
    logic [7:0]  mask;
    logic [7:0]  dp;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [7:0]  an_n;
    logic [2:0]  digit_idx;
    logic        frame_done;

    seg_scan8 #(.DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .value      (value),
        .mask       (mask),
        .dp         (dp),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model: position within the frame, and the two display sets as plain values
    int          m_pos;
    logic        m_pend;
    logic [31:0] m_pv, m_av;
    logic [7:0]  m_pm, m_pd, m_am, m_ad;
    logic        m_blank;
    logic        m_fd;
    logic [6:0]  seg_tab [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_pend = 1'b0;
        m_pv = '0; m_pm = '0; m_pd = '0;
        m_av = '0; m_am = '0; m_ad = '0;
        m_blank = 1'b1; m_fd = 1'b0;
    endtask

    task automatic model_edge();
        logic bnd;
        if (!en) begin
            m_pos = 0;
            if (load) begin
                m_av = value; m_am = mask; m_ad = dp;
            end else if (m_pend) begin
                m_av = m_pv; m_am = m_pm; m_ad = m_pd;
            end
            m_pend = 1'b0; m_blank = 1'b1; m_fd = 1'b0;
        end else begin
            bnd = (m_pos == FRAME - 1);
            if (bnd) begin
                if (load) begin
                    m_av = value; m_am = mask; m_ad = dp;
                end else if (m_pend) begin
                    m_av = m_pv; m_am = m_pm; m_ad = m_pd;
                end
                m_pend = 1'b0;
            end else if (load) begin
                m_pv = value; m_pm = mask; m_pd = dp; m_pend = 1'b1;
            end
            m_pos = (m_pos + 1) % FRAME;
            m_blank = 1'b0; m_fd = bnd;
        end
    endtask

    task automatic check_outputs();
        int         d;
        logic       lit;
        logic [7:0] one_hot;
        d = m_pos / DIV;
        lit = !m_blank && m_am[d];
        one_hot = 8'h01 << d;
        chk("an_n", {24'h0, an_n}, {24'h0, lit ? ~one_hot : 8'hFF});
        chk("seg_n", {25'h0, seg_n}, {25'h0, lit ? seg_tab[m_av[4*d +: 4]] : 7'h7F});
        chk("dp_n", {31'h0, dp_n}, {31'h0, lit ? ~m_ad[d] : 1'b1});
        chk("digit_idx", {29'h0, digit_idx}, d);
        chk("frame_done", {31'h0, frame_done}, {31'h0, m_fd});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic advance_to(input int pos);
        for (int i = 0; i < 2 * FRAME && m_pos != pos; i++) tick();
        if (m_pos != pos) begin
            n_errors++;
            $error("FAIL advance_to: position=%0d required=%0d", m_pos, pos);
        end
    endtask

    task automatic set_in(input logic [31:0] v, input logic [7:0] m, input logic [7:0] d);
        value = v; mask = m; dp = d;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_an"}, {24'h0, an_n}, 32'hFF);
        chk({tag, "_seg"}, {25'h0, seg_n}, 32'h7F);
        chk({tag, "_dp"}, {31'h0, dp_n}, 32'h1);
        chk({tag, "_fd"}, {31'h0, frame_done}, 32'h0);
        chk({tag, "_idx"}, {29'h0, digit_idx}, 32'h0);
    endtask

    initial begin
        int last_fd;
        int n_fd;
        int n_ones;
        int n_lit;

        seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
        seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
        seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
        seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
        seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010;
        seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;

        rst_n = 1'b1; en = 1'b0; load = 1'b0;
        set_in(32'h0, 8'h0, 8'h0);
        model_reset();

        // Power-on reset
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("por");
        #9 rst_n = 1'b1;
        tick();
        tick();

        // Scan: load while disabled, then enable
        set_in(32'h76543210, 8'hFF, 8'h01);
        load = 1'b1;
        tick();
        load = 1'b0;
        en = 1'b1;
        last_fd = -1;
        n_fd = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            if (frame_done) begin
                n_fd++;
                if (last_fd >= 0) chk("fd_period", cyc - last_fd, FRAME);
                last_fd = cyc;
            end
        end
        chk("fd_count", n_fd, 3);

        // Hex table: staged load mid-frame, shown from next frame
        advance_to(2 * DIV + 1);
        set_in(32'hFEDCBA98, 8'hFF, 8'h00);
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) tick();

        // Tear-free: two loads mid-frame, only the last survives
        n_ones = 0;
        advance_to(3 * DIV);
        set_in(32'h11111111, 8'hFF, 8'h00);
        load = 1'b1;
        tick();
        load = 1'b0;
        advance_to(5 * DIV);
        set_in(32'h22222222, 8'hFF, 8'h00);
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (an_n != 8'hFF && seg_n == 7'b1001111) n_ones++;
        end
        chk("tear_ones", n_ones, 0);
        chk("tear_seg2", {25'h0, seg_n}, {25'h0, seg_tab[2]});

        // Boundary bypass: load in the boundary cycle goes straight to active
        advance_to(FRAME - 1);
        set_in(32'h0000000F, 8'h01, 8'h00);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("bypass_fd", {31'h0, frame_done}, 32'h1);
        chk("bypass_seg", {25'h0, seg_n}, 32'b0111000);
        chk("bypass_an", {24'h0, an_n}, 32'hFE);
        for (int i = 0; i < FRAME; i++) tick();

        // Enable: drop mid-frame, load while disabled, re-enable
        advance_to(2 * DIV + 1);
        en = 1'b0;
        tick();
        chk("endrop_an", {24'h0, an_n}, 32'hFF);
        chk("endrop_idx", {29'h0, digit_idx}, 32'h0);
        set_in(32'h89ABCDEF, 8'hFF, 8'h80);
        load = 1'b1;
        tick();
        load = 1'b0;
        en = 1'b1;
        tick();
        chk("enrise_seg", {25'h0, seg_n}, 32'b0111000);
        chk("enrise_an", {24'h0, an_n}, 32'hFE);
        for (int i = 0; i < FRAME; i++) tick();

        // Reset mid-frame with a pending load outstanding
        advance_to(3 * DIV + 2);
        set_in(32'h55555555, 8'hFF, 8'hFF);
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        model_reset();
        #3 rst_n = 1'b1;
        n_lit = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (an_n != 8'hFF) n_lit++;
        end
        chk("post_rst_blank", n_lit, 0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            en = ($urandom_range(0, 30) != 0);
            load = ($urandom_range(0, 9) == 0);
            set_in($urandom, 8'($urandom), 8'($urandom));
            tick();
        end
        load = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
